// File: rtl/dm_pkg.sv
// Shared definitions for the sized data memory: access-size encodings, FSM states
// and a byte-count helper.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    // Reserved size reports one byte so address arithmetic never underflows;
    // the access is rejected separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Turns four big-endian fetched bytes (first byte in [31:24]) into a right-aligned,
// sign- or zero-extended load value.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] fetched,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = 32'h0;
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & fetched[31]}}, fetched[31:24]};
            SZ_HALF: rdata = {{16{sign_ext & fetched[31]}}, fetched[31:16]};
            SZ_WORD: rdata = fetched;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory with byte/half/word accesses and a
// request/ready handshake with WAIT_CYCLES wait states. Define DM_MISALIGN_CHECK_EN
// to reject misaligned accesses instead of force-aligning them.
module data_mem_sized
    import dm_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemReq,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [31:0]       MemWriteData,
    output logic [31:0]       MemReadData,
    output logic              MemReady,
    output logic              MemErr
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    dm_state_t         state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              cap_write_reg;
    logic [1:0]        cap_size_reg;
    logic              cap_signed_reg;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [31:0]       cap_wdata_reg;
    logic              ready_reg;
    logic              err_reg;
    logic [31:0]       rdata_reg;

    logic              accept;
    logic              enter_resp;
    logic              mem_we;

    // With zero wait states the access happens on the capture edge itself, so the
    // live inputs are used while idle and the captured copy afterwards.
    logic              eff_write;
    logic [1:0]        eff_size;
    logic              eff_signed;
    logic [ADDR_W-1:0] eff_addr;
    logic [31:0]       eff_wdata;

    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        nbytes;
    logic [ADDR_W:0]   end_addr;
    logic              misalign;
    logic              range_err;
    logic              acc_err;
    logic [31:0]       wdata_left;
    logic [31:0]       fetched;
    logic [31:0]       load_val;

    logic [3:0]        lane_en;
    logic [IDX_W-1:0]  lane_idx [4];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (MemReq) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept     = (state_reg == IDLE) && MemReq;
    assign enter_resp = (state_next == RESP);

    always_comb begin
        if (state_reg == IDLE) begin
            eff_write  = MemWrite;
            eff_size   = MemSize;
            eff_signed = MemSigned;
            eff_addr   = MemAddr;
            eff_wdata  = MemWriteData;
        end else begin
            eff_write  = cap_write_reg;
            eff_size   = cap_size_reg;
            eff_signed = cap_signed_reg;
            eff_addr   = cap_addr_reg;
            eff_wdata  = cap_wdata_reg;
        end
    end

    assign nbytes = size_bytes(eff_size);

`ifdef DM_MISALIGN_CHECK_EN
    always_comb begin
        acc_addr = eff_addr;
        misalign = ((eff_size == SZ_HALF) && eff_addr[0]) ||
                   ((eff_size == SZ_WORD) && (eff_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        acc_addr = eff_addr;
        misalign = 1'b0;
        case (eff_size)
            SZ_HALF: acc_addr = {eff_addr[ADDR_W-1:1], 1'b0};
            SZ_WORD: acc_addr = {eff_addr[ADDR_W-1:2], 2'b00};
            default: acc_addr = eff_addr;
        endcase
    end
`endif

    // One extra bit keeps the last-byte address from wrapping near the top of the space.
    assign end_addr  = {1'b0, acc_addr} + {{(ADDR_W-2){1'b0}}, nbytes} - (ADDR_W+1)'(1);
    assign range_err = (end_addr >= DEPTH_EXT);
    assign acc_err   = (eff_size == SZ_RSVD) || range_err || misalign;

    always_comb begin
        wdata_left = 32'h0;
        case (eff_size)
            SZ_BYTE: wdata_left = {eff_wdata[7:0], 24'h0};
            SZ_HALF: wdata_left = {eff_wdata[15:0], 16'h0};
            SZ_WORD: wdata_left = eff_wdata;
            default: wdata_left = 32'h0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi]  = !acc_err && (3'(gi) < nbytes);
            assign lane_idx[gi] = lane_en[gi] ? IDX_W'(acc_addr + ADDR_W'(gi)) : '0;
            assign fetched[31-8*gi -: 8] = lane_en[gi] ? mem[lane_idx[gi]] : 8'h00;
        end
    endgenerate

    dm_lane_align u_align (
        .fetched  (fetched),
        .size     (eff_size),
        .sign_ext (eff_signed),
        .rdata    (load_val)
    );

    // Gating with rst_n keeps a reset-interrupted store from committing.
    assign mem_we = rst_n && enter_resp && eff_write;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[lane_idx[i]] <= wdata_left[31-8*i -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            cap_write_reg  <= 1'b0;
            cap_size_reg   <= SZ_BYTE;
            cap_signed_reg <= 1'b0;
            cap_addr_reg   <= '0;
            cap_wdata_reg  <= 32'h0;
            ready_reg      <= 1'b0;
            err_reg        <= 1'b0;
            rdata_reg      <= 32'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                cap_write_reg  <= MemWrite;
                cap_size_reg   <= MemSize;
                cap_signed_reg <= MemSigned;
                cap_addr_reg   <= MemAddr;
                cap_wdata_reg  <= MemWriteData;
            end
            ready_reg <= enter_resp;
            err_reg   <= enter_resp && acc_err;
            if (enter_resp) begin
                rdata_reg <= (eff_write || acc_err) ? 32'h0 : load_val;
            end
        end
    end

    assign MemReady    = ready_reg;
    assign MemErr      = err_reg;
    assign MemReadData = rdata_reg;

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: a zero-wait instance for table and random traffic,
// and a three-wait-state instance for latency, throughput and reset corner cases.
module tb_data_mem_sized;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        mw = 1'b0;
    logic [1:0]  ms = 2'b00;
    logic        msg = 1'b0;
    logic [31:0] ma = 32'h0;
    logic [31:0] mwd = 32'h0;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, err0, err1;

    int checks = 0;
    int failures = 0;

    logic [7:0] model0 [128];

    always #5 clk = ~clk;

    data_mem_sized #(.DEPTH_BYTES(128), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .MemReq(req0), .MemWrite(mw), .MemSize(ms),
        .MemSigned(msg), .MemAddr(ma), .MemWriteData(mwd),
        .MemReadData(rd0), .MemReady(rdy0), .MemErr(err0)
    );

    data_mem_sized #(.DEPTH_BYTES(128), .ADDR_W(32), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .MemReq(req1), .MemWrite(mw), .MemSize(ms),
        .MemSigned(msg), .MemAddr(ma), .MemWriteData(mwd),
        .MemReadData(rd1), .MemReady(rdy1), .MemErr(err1)
    );

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Issue one access on the chosen instance; lat counts edges from the sampling
    // edge up to the edge that raised MemReady (0 means it never came).
    task automatic txn(input int which, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        mw = w; ms = sz; msg = sg; ma = a; mwd = wd;
        if (which == 0) req0 = 1'b1; else req1 = 1'b1;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if ((which == 0 && rdy0 === 1'b1) || (which == 1 && rdy1 === 1'b1)) begin
                lat = k;
                rd  = (which == 0) ? rd0 : rd1;
                er  = (which == 0) ? err0 : err1;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        $display("txn dut%0d w=%0d sz=%0d sg=%0d a=0x%08h wd=0x%08h -> rd=0x%08h err=%0d lat=%0d",
                 which, w, sz, sg, a, wd, rd, er, lat);
    endtask

    // Reference behaviour: size -> byte count, alignment/range rules, big-endian
    // byte order, extension by arithmetic on the assembled value.
    task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int nb;
        longint unsigned base;
        longint unsigned val;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        er = (nb == 0);
        base = longint'(a);
`ifdef DM_MISALIGN_CHECK_EN
        if (nb > 1 && (base % nb) != 0) er = 1'b1;
`else
        if (nb > 1) base = base - (base % nb);
`endif
        if (!er && base + nb > 128) er = 1'b1;
        rd = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < nb; i++)
                    model0[base + i] = 8'((wd >> (8 * (nb - 1 - i))) & 32'hFF);
            end else begin
                val = 0;
                for (int i = 0; i < nb; i++) val = (val << 8) | longint'(model0[base + i]);
                if (sg && val >= (64'd1 << (8 * nb - 1))) val = val + (64'd1 << 32) - (64'd1 << (8 * nb));
                rd = val[31:0];
            end
        end
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        int          bad;
        logic [7:0]  b;

        // Reset state
        #12;
        chk("reset_rd0", rd0, 32'h0);
        chk("reset_rdy0", {31'h0, rdy0}, 32'h0);
        chk("reset_err0", {31'h0, err0}, 32'h0);
        chk("reset_rdy1", {31'h0, rdy1}, 32'h0);

        for (int i = 0; i < 128; i++) begin
            b = 8'($urandom);
            dut0.mem[i] = b;
            model0[i] = b;
            dut1.mem[i] = 8'(i);
        end
        dut0.mem[4] = 8'h80;   model0[4] = 8'h80;
        dut0.mem[5] = 8'h7F;   model0[5] = 8'h7F;
        dut0.mem[124] = 8'hDE; model0[124] = 8'hDE;
        dut0.mem[125] = 8'hAD; model0[125] = 8'hAD;
        dut0.mem[126] = 8'hA5; model0[126] = 8'hA5;
        dut0.mem[127] = 8'h5A; model0[127] = 8'h5A;
        dut1.mem[0] = 8'hC0; dut1.mem[1] = 8'hFF; dut1.mem[2] = 8'hEE; dut1.mem[3] = 8'h01;

        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors on the zero-wait instance
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'd8,   32'h11223344, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd8,   32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'd4,   32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'd4,   32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'd4,   32'h0,        32'hFFFF807F, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd124, 32'h0,        32'hDEADA55A, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd128, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'd128, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'd126, 32'h0,        32'h0000A55A, 1'b0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'd0,   32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'd127, 32'h0,        32'h0000005A, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h00000000, 1'b1});
`ifdef DM_MISALIGN_CHECK_EN
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd126, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'd126, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'd5,   32'h0000ABCD, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'd4,   32'h0,        32'h0000807F, 1'b0});
`else
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd126, 32'h0,        32'hDEADA55A, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'd5,   32'h0000ABCD, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'd4,   32'h0,        32'h0000ABCD, 1'b0});
`endif

        foreach (vecs[i]) begin
            txn(0, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, rd, er, lat);
            model_access(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, mrd, mer);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
        end

        chk("mem8",   32'(dut0.mem[8]),   32'h11);
        chk("mem11",  32'(dut0.mem[11]),  32'h44);
        chk("mem126", 32'(dut0.mem[126]), 32'hA5);
        chk("mem127", 32'(dut0.mem[127]), 32'h5A);
`ifdef DM_MISALIGN_CHECK_EN
        chk("mem4_after_half", 32'(dut0.mem[4]), 32'h80);
        chk("mem5_after_half", 32'(dut0.mem[5]), 32'h7F);
`else
        chk("mem4_after_half", 32'(dut0.mem[4]), 32'hAB);
        chk("mem5_after_half", 32'(dut0.mem[5]), 32'hCD);
`endif

        // Random traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            logic        rw, rsg;
            logic [1:0]  rsz;
            logic [31:0] ra, rwd;
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            rsg = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 131));
            rwd = $urandom;
            txn(0, rw, rsz, rsg, ra, rwd, rd, er, lat);
            model_access(rw, rsz, rsg, ra, rwd, mrd, mer);
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd1);
            chk($sformatf("rnd%0d_rd", n), rd, mrd);
            chk($sformatf("rnd%0d_err", n), {31'h0, er}, {31'h0, mer});
        end
        bad = 0;
        for (int i = 0; i < 128; i++) if (dut0.mem[i] !== model0[i]) bad++;
        chk("array_vs_model_mismatches", 32'(bad), 32'd0);

        // Three wait states: latency
        txn(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, rd, er, lat);
        chk("w3_lat", 32'(lat), 32'd4);
        chk("w3_rd", rd, 32'hC0FFEE01);

        // Three wait states: MemReq held high gives one access per five edges
        @(posedge clk); #1;
        mw = 1'b0; ms = 2'd0; msg = 1'b0; ma = 32'd1; req1 = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rdy1 === 1'b1) begin lat = k; break; end
        end
        chk("w3_b2b_first_lat", 32'(lat), 32'd4);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rdy1 === 1'b1) begin lat = k; break; end
        end
        chk("w3_b2b_spacing", 32'(lat), 32'd5);
        chk("w3_b2b_rd", rd1, 32'h000000FF);
        req1 = 1'b0;
        $display("txn dut1 back-to-back byte loads at 0x1 spacing=%0d rd=0x%08h", lat, rd1);

        // Three wait states: reset during a pending store
        @(posedge clk); #1;
        @(posedge clk); #1;
        mw = 1'b1; ms = 2'd2; ma = 32'd0; mwd = 32'h12345678; req1 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; req1 = 1'b0;
        #1;
        chk("rst_mid_rd1", rd1, 32'h0);
        chk("rst_mid_rdy1", {31'h0, rdy1}, 32'h0);
        chk("rst_mid_err1", {31'h0, err1}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rdy1 !== 1'b0) bad++;
        end
        chk("rst_no_ready", 32'(bad), 32'd0);
        chk("rst_word_kept", {dut1.mem[0], dut1.mem[1], dut1.mem[2], dut1.mem[3]}, 32'hC0FFEE01);
        $display("txn dut1 store word 0x12345678 at 0x0 aborted by reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
